// File: rtl/sd_cmd_phy_ext.sv
// SD CMD-line engine: serialises a 48-bit command with CRC7 and captures a
// short/long response, with response timeout, optional R1b busy wait and abort.
module sd_cmd_phy_ext #(
  parameter int INIT_DELAY   = 74,
  parameter int RESP_TIMEOUT = 64,
  parameter int BUSY_TIMEOUT = 65535,
  parameter int CNT_W        = 17
) (
  input  logic         sd_clk,
  input  logic         rst,
  input  logic [3:0]   setting_i,
  input  logic [39:0]  cmd_i,
  input  logic         start_i,
  input  logic         abort_i,
  output logic         ready_o,
  output logic         finish_o,
  output logic [119:0] response_o,
  output logic         crc_ok_o,
  output logic         index_ok_o,
  output logic         timeout_o,
  input  logic         cmd_dat_i,
  output logic         cmd_out_o,
  output logic         cmd_oe_o,
  input  logic         dat0_i
);

  typedef enum logic [2:0] {
    INIT, IDLE, WRITE, READ_WAIT, READ, BUSY_WAIT, FINISH
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [5:0]         idx_q;
  logic [3:0]         set_q;
  logic [47:0]        tx_q;
  logic [134:0]       rx_q;
  logic [6:0]         crc_q;

  logic [47:0]        frame_w;
  logic [135:0]       rx_nx;
  logic [CNT_W-1:0]   last_idx;
  logic               crc_en;
  logic               busy_state;
  logic               unused_bits;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  function automatic logic [47:0] build_frame(input logic [39:0] c);
    logic [6:0] crc;
    crc = 7'd0;
    for (int i = 39; i >= 0; i--) crc = crc7_step(crc, c[i]);
    return {c, crc, 1'b1};
  endfunction

  assign frame_w     = build_frame(cmd_i);
  assign rx_nx       = {rx_q, cmd_dat_i};
  assign last_idx    = set_q[1] ? CNT_W'(135) : CNT_W'(47);
  assign busy_state  = (state == WRITE) || (state == READ_WAIT) ||
                       (state == READ)  || (state == BUSY_WAIT);
  // Start/transmission bits and the stop bit are never checked.
  assign unused_bits = &{1'b0, rx_nx[135:134], rx_nx[0]};

  // CRC covers frame bits 47..8 (short) or 127..8 (long); cnt is the index
  // of the bit arriving now, counting the start bit as 0.
  always_comb begin
    crc_en = 1'b0;
    if (set_q[1]) crc_en = (cnt >= CNT_W'(8)) && (cnt <= CNT_W'(127));
    else          crc_en = (cnt <= CNT_W'(39));
  end

  always_ff @(posedge sd_clk) begin
    case (state)
      IDLE: if (start_i) begin
        idx_q <= cmd_i[37:32];
        set_q <= setting_i[0] ? setting_i : 4'b0000;
        tx_q  <= {frame_w[46:0], 1'b0};
      end
      WRITE:     tx_q <= {tx_q[46:0], 1'b0};
      READ_WAIT: begin
        rx_q  <= '0;
        crc_q <= 7'd0;
      end
      READ: begin
        rx_q <= rx_nx[134:0];
        if (crc_en) crc_q <= crc7_step(crc_q, cmd_dat_i);
      end
      default: ;
    endcase
  end

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      state      <= INIT;
      cnt        <= '0;
      cmd_oe_o   <= 1'b1;
      cmd_out_o  <= 1'b1;
      ready_o    <= 1'b0;
      finish_o   <= 1'b0;
      response_o <= '0;
      crc_ok_o   <= 1'b0;
      index_ok_o <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      finish_o <= 1'b0;
      if (abort_i && busy_state) begin
        state      <= IDLE;
        cnt        <= '0;
        cmd_oe_o   <= 1'b0;
        cmd_out_o  <= 1'b1;
        ready_o    <= 1'b1;
        response_o <= '0;
        crc_ok_o   <= 1'b0;
        index_ok_o <= 1'b0;
        timeout_o  <= 1'b0;
      end else begin
        case (state)
          INIT: begin
            if (cnt == CNT_W'(INIT_DELAY - 1)) begin
              state    <= IDLE;
              cnt      <= '0;
              cmd_oe_o <= 1'b0;
              ready_o  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          IDLE: begin
            if (start_i) begin
              state      <= WRITE;
              cnt        <= '0;
              ready_o    <= 1'b0;
              cmd_oe_o   <= 1'b1;
              cmd_out_o  <= frame_w[47];
              response_o <= '0;
              crc_ok_o   <= 1'b0;
              index_ok_o <= 1'b0;
              timeout_o  <= 1'b0;
            end
          end
          WRITE: begin
            if (cnt == CNT_W'(47)) begin
              cnt       <= '0;
              cmd_oe_o  <= 1'b0;
              cmd_out_o <= 1'b1;
              if (set_q[0]) begin
                state <= READ_WAIT;
              end else begin
                state    <= FINISH;
                finish_o <= 1'b1;
                crc_ok_o <= 1'b1;
              end
            end else begin
              cmd_out_o <= tx_q[47];
              cnt       <= cnt + CNT_W'(1);
            end
          end
          READ_WAIT: begin
            if (!cmd_dat_i) begin
              state <= READ;
              cnt   <= CNT_W'(1);
            end else if (cnt == CNT_W'(RESP_TIMEOUT - 1)) begin
              state      <= FINISH;
              cnt        <= '0;
              finish_o   <= 1'b1;
              timeout_o  <= 1'b1;
              crc_ok_o   <= 1'b0;
              index_ok_o <= 1'b0;
              response_o <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          READ: begin
            if (cnt == last_idx) begin
              cnt <= '0;
              if (set_q[1]) begin
                response_o <= rx_nx[127:8];
                index_ok_o <= (rx_nx[133:128] == 6'h3F);
              end else begin
                response_o <= {88'd0, rx_nx[39:8]};
                index_ok_o <= (rx_nx[45:40] == idx_q);
              end
              crc_ok_o <= !set_q[2] || (crc_q == rx_nx[7:1]);
              if (set_q[3]) begin
                state <= BUSY_WAIT;
              end else begin
                state    <= FINISH;
                finish_o <= 1'b1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          BUSY_WAIT: begin
            // DAT0 may still reflect the previous level for two cycles.
            if ((cnt >= CNT_W'(2)) && dat0_i) begin
              state    <= FINISH;
              cnt      <= '0;
              finish_o <= 1'b1;
            end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
              state     <= FINISH;
              cnt       <= '0;
              finish_o  <= 1'b1;
              timeout_o <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          FINISH: begin
            state   <= IDLE;
            ready_o <= 1'b1;
          end
          default: state <= INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_phy_ext.sv
// Directed bench for sd_cmd_phy_ext: a card model drives CMD/DAT0 and a
// scoreboard queue holds the expected completion status of each command.
module tb_sd_cmd_phy_ext;

  logic         sd_clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   setting_i = 4'd0;
  logic [39:0]  cmd_i = 40'd0;
  logic         start_i = 1'b0;
  logic         abort_i = 1'b0;
  logic         ready_o, finish_o, crc_ok_o, index_ok_o, timeout_o;
  logic [119:0] response_o;
  logic         cmd_dat_i = 1'b1;
  logic         cmd_out_o, cmd_oe_o;
  logic         dat0_i = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [119:0] resp;
    logic         crc_ok;
    logic         index_ok;
    logic         timeout;
  } exp_t;
  exp_t sb[$];

  sd_cmd_phy_ext dut (
    .sd_clk(sd_clk), .rst(rst), .setting_i(setting_i), .cmd_i(cmd_i),
    .start_i(start_i), .abort_i(abort_i), .ready_o(ready_o),
    .finish_o(finish_o), .response_o(response_o), .crc_ok_o(crc_ok_o),
    .index_ok_o(index_ok_o), .timeout_o(timeout_o), .cmd_dat_i(cmd_dat_i),
    .cmd_out_o(cmd_out_o), .cmd_oe_o(cmd_oe_o), .dat0_i(dat0_i)
  );

  always #5 sd_clk = ~sd_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] m_crc(input logic [127:0] d, input int n);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] m_frame(input logic [39:0] c);
    return {c, m_crc(128'(c), 40), 1'b1};
  endfunction

  function automatic logic [135:0] m_r1(input logic [5:0] idx, input logic [31:0] st);
    logic [39:0] p;
    p = {2'b00, idx, st};
    return 136'({p, m_crc(128'(p), 40), 1'b1});
  endfunction

  task automatic tick();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [119:0] r, input logic c, input logic i, input logic t);
    exp_t e;
    e.resp = r; e.crc_ok = c; e.index_ok = i; e.timeout = t;
    sb.push_back(e);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 136'(1), 136'(0));
    end else begin
      e = sb.pop_front();
      chk({tag, ".resp"},     136'(response_o), 136'(e.resp));
      chk({tag, ".crc_ok"},   136'(crc_ok_o),   136'(e.crc_ok));
      chk({tag, ".index_ok"}, 136'(index_ok_o), 136'(e.index_ok));
      chk({tag, ".timeout"},  136'(timeout_o),  136'(e.timeout));
    end
  endtask

  task automatic wait_finish(input int max, output int n);
    n = 0;
    while (!finish_o && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset(input string tag, input bit poke_start);
    int n;
    bit line_ok;
    rst = 1'b1;
    tick(); tick();
    chk({tag, ".rst_oe"},    136'(cmd_oe_o),   136'(1));
    chk({tag, ".rst_out"},   136'(cmd_out_o),  136'(1));
    chk({tag, ".rst_ready"}, 136'(ready_o),    136'(0));
    chk({tag, ".rst_fin"},   136'(finish_o),   136'(0));
    chk({tag, ".rst_stat"},  136'({response_o, crc_ok_o, index_ok_o, timeout_o}), 136'(0));
    rst = 1'b0;
    n = 0;
    line_ok = 1'b1;
    while (!ready_o && n < 200) begin
      if (!(cmd_oe_o && cmd_out_o)) line_ok = 1'b0;
      start_i = poke_start && (n == 10);
      cmd_i = 40'h4000000000;
      tick();
      n++;
    end
    start_i = 1'b0;
    chk({tag, ".init_len"},  136'(n),        136'(74));
    chk({tag, ".init_line"}, 136'(line_ok),  136'(1));
    chk({tag, ".idle_oe"},   136'(cmd_oe_o), 136'(0));
  endtask

  task automatic send_cmd(input logic [39:0] c, input logic [3:0] s, output logic [47:0] fr);
    cmd_i = c; setting_i = s; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 48; k++) begin
      fr[47 - k] = cmd_oe_o ? cmd_out_o : 1'bx;
      tick();
    end
    chk("release_oe", 136'(cmd_oe_o), 136'(0));
  endtask

  task automatic card_send(input logic [135:0] bits, input int len, input int dly);
    repeat (dly) tick();
    for (int i = len - 1; i >= 0; i--) begin
      cmd_dat_i = bits[i];
      tick();
    end
    cmd_dat_i = 1'b1;
  endtask

  task automatic back_to_idle(input string tag);
    tick();
    chk({tag, ".ready"},  136'(ready_o),  136'(1));
    chk({tag, ".fin_off"}, 136'(finish_o), 136'(0));
  endtask

  initial begin
    logic [47:0]  fr;
    logic [135:0] rb;
    logic [119:0] cid;
    logic [39:0]  c17;
    int n;
    int fins;

    do_reset("por", 1'b1);

    // CMD0, no response
    push_exp(120'd0, 1'b1, 1'b0, 1'b0);
    send_cmd(40'h4000000000, 4'b0000, fr);
    chk("cmd0.frame",  136'(fr),       136'(48'h400000000095));
    chk("cmd0.fin49",  136'(finish_o), 136'(1));
    check_result("cmd0");
    back_to_idle("cmd0");

    // CMD17, R1 with good CRC
    c17 = {2'b01, 6'd17, 32'h00001000};
    push_exp(120'h900, 1'b1, 1'b1, 1'b0);
    send_cmd(c17, 4'b0101, fr);
    chk("cmd17.frame", 136'(fr), 136'(m_frame(c17)));
    card_send(136'(48'h110000090067), 48, 2);
    chk("cmd17.fin", 136'(finish_o), 136'(1));
    check_result("cmd17");
    back_to_idle("cmd17");

    // same with one payload bit flipped
    push_exp(120'h1900, 1'b0, 1'b1, 1'b0);
    send_cmd(c17, 4'b0101, fr);
    card_send(136'(48'h110000090067 ^ 48'h000000100000), 48, 3);
    chk("cmd17f.fin", 136'(finish_o), 136'(1));
    check_result("cmd17f");
    back_to_idle("cmd17f");

    // flipped bit with CRC checking disabled
    push_exp(120'h1900, 1'b1, 1'b1, 1'b0);
    send_cmd(c17, 4'b0001, fr);
    card_send(136'(48'h110000090067 ^ 48'h000000100000), 48, 2);
    check_result("cmd17nc");
    back_to_idle("cmd17nc");

    // wrong index in an otherwise valid R1
    push_exp(120'h900, 1'b1, 1'b0, 1'b0);
    send_cmd(c17, 4'b0101, fr);
    card_send(m_r1(6'd18, 32'h900), 48, 4);
    check_result("badidx");
    back_to_idle("badidx");

    // CMD2, long response with random CID
    cid[31:0]   = $urandom();
    cid[63:32]  = $urandom();
    cid[95:64]  = $urandom();
    cid[119:96] = 24'($urandom());
    rb = {8'h3F, cid, m_crc(128'(cid), 120), 1'b1};
    push_exp(cid, 1'b1, 1'b1, 1'b0);
    send_cmd({2'b01, 6'd2, 32'h0}, 4'b0111, fr);
    card_send(rb, 136, 5);
    chk("cmd2.fin", 136'(finish_o), 136'(1));
    check_result("cmd2");
    back_to_idle("cmd2");

    // silent card
    push_exp(120'd0, 1'b0, 1'b0, 1'b1);
    send_cmd({2'b01, 6'd8, 32'h1AA}, 4'b0101, fr);
    wait_finish(200, n);
    chk("silent.latency", 136'(n), 136'(64));
    check_result("silent");
    back_to_idle("silent");

    // next command after timeout completes normally
    push_exp(120'h900, 1'b1, 1'b1, 1'b0);
    send_cmd(c17, 4'b0101, fr);
    card_send(136'(48'h110000090067), 48, 2);
    check_result("after_to");
    back_to_idle("after_to");

    // R1b: DAT0 low for 300 cycles
    push_exp(120'h700, 1'b1, 1'b1, 1'b0);
    send_cmd({2'b01, 6'd7, 32'h12340000}, 4'b1101, fr);
    dat0_i = 1'b0;
    card_send(m_r1(6'd7, 32'h700), 48, 2);
    fins = 0;
    repeat (300) begin
      if (finish_o) fins++;
      tick();
    end
    chk("r1b.early_fin", 136'(fins), 136'(0));
    dat0_i = 1'b1;
    wait_finish(20, n);
    chk("r1b.latency", 136'(n), 136'(1));
    check_result("r1b");
    back_to_idle("r1b");

    // abort in the middle of busy wait
    send_cmd({2'b01, 6'd7, 32'h12340000}, 4'b1101, fr);
    dat0_i = 1'b0;
    card_send(m_r1(6'd7, 32'h700), 48, 2);
    repeat (50) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_b.ready", 136'(ready_o),  136'(1));
    chk("abort_b.fin",   136'(finish_o), 136'(0));
    chk("abort_b.line",  136'({cmd_oe_o, cmd_out_o}), 136'(2'b01));
    chk("abort_b.stat",  136'({response_o, crc_ok_o, index_ok_o, timeout_o}), 136'(0));
    dat0_i = 1'b1;
    fins = 0;
    repeat (10) begin
      if (finish_o) fins++;
      tick();
    end
    chk("abort_b.no_fin", 136'(fins), 136'(0));

    // abort while the command is still being sent
    cmd_i = c17; setting_i = 4'b0101; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (10) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_w.ready", 136'(ready_o), 136'(1));
    chk("abort_w.line",  136'({cmd_oe_o, cmd_out_o}), 136'(2'b01));

    // reset in the middle of a command reruns the init delay
    cmd_i = c17; setting_i = 4'b0101; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (20) tick();
    do_reset("midrst", 1'b0);

    chk("sb.drained", 136'(sb.size()), 136'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
